decode_packet: RTL and testbench

Receive-side counterpart of the packet encoder. It consumes 64-bit flits from the Aurora RX FIFO and reassembles each run of 19 flits into one 1034-bit DFX word: 1024-bit data plus 10-bit destination address. It checks sequence, source and TTL fields, then presents the rebuilt packet to the router controller through a valid/ready handshake.

---
 rtl/decode_packet.sv | 140 ++++++++++++++
 tb/tb_decode_packet.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_packet.sv
// Reassembles 19 Aurora flits into one 1034-bit DFX word.
// Checks seq/src/TTL and hands the packet out over valid/ready.
module decode_packet #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int NUMBER_PACKET     = 19,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int FLIT_PAYLOAD      = 55
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flit_valid_i,
  output logic                         flit_ready_o,
  input  logic [AURORA_DATA_WIDTH-1:0] flit_data_i,
  output logic                         decode_valid_o,
  input  logic                         decode_ready_i,
  output logic [DATA_WIDTH-1:0]        decode_data_o,
  output logic [ADDR_WIDTH-1:0]        decode_dst_addr_o,
  output logic [1:0]                   decode_src_o,
  output logic [1:0]                   decode_ttl_o,
  output logic                         err_seq_o,
  output logic                         err_ttl_o,
  output logic [15:0]                  pkt_count_o
);

  localparam int LAST_BASE = (NUMBER_PACKET - 1) * FLIT_PAYLOAD;
  localparam int LAST_W    = DATA_DFX_WIDTH - LAST_BASE;
  localparam logic [4:0] LAST_SEQ = 5'(NUMBER_PACKET - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OUTPUT
  } state_t;

  state_t                    state;
  logic [DATA_DFX_WIDTH-1:0] dfx;
  logic [4:0]                exp_seq;
  logic [1:0]                src_q;
  logic [1:0]                ttl_q;

  logic [FLIT_PAYLOAD-1:0] f_pay;
  logic [1:0]              f_ttl;
  logic [4:0]              f_seq;
  logic [1:0]              f_src;
  logic                    take;
  logic                    match;
  logic [10:0]             base;

  assign f_pay = flit_data_i[AURORA_DATA_WIDTH-1 -: FLIT_PAYLOAD];
  assign f_ttl = flit_data_i[8:7];
  assign f_seq = flit_data_i[6:2];
  assign f_src = flit_data_i[1:0];

  assign flit_ready_o = (state != OUTPUT);
  assign take  = flit_valid_i && flit_ready_o;
  assign match = (f_seq == exp_seq) && (f_src == src_q);
  assign base  = 11'(exp_seq) * 11'(FLIT_PAYLOAD);

  // The buffer is only written outside OUTPUT, so it doubles as
  // the held output register while the controller stalls.
  assign decode_data_o     = dfx[DATA_DFX_WIDTH-1:ADDR_WIDTH];
  assign decode_dst_addr_o = dfx[ADDR_WIDTH-1:0];
  assign decode_src_o      = src_q;
  assign decode_ttl_o      = ttl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      dfx            <= '0;
      exp_seq        <= '0;
      src_q          <= '0;
      ttl_q          <= '0;
      decode_valid_o <= 1'b0;
      err_seq_o      <= 1'b0;
      err_ttl_o      <= 1'b0;
      pkt_count_o    <= '0;
    end else begin
      err_seq_o <= 1'b0;
      err_ttl_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            if (f_seq == 5'd0) begin
              dfx[0 +: FLIT_PAYLOAD] <= f_pay;
              src_q   <= f_src;
              ttl_q   <= f_ttl;
              exp_seq <= 5'd1;
              state   <= COLLECT;
            end else begin
              err_seq_o <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (take) begin
            if (match) begin
              if (exp_seq == LAST_SEQ) begin
                dfx[DATA_DFX_WIDTH-1 -: LAST_W] <= flit_data_i[9 +: LAST_W];
                exp_seq <= 5'd0;
                if (ttl_q != 2'd0) begin
                  decode_valid_o <= 1'b1;
                  state          <= OUTPUT;
                end else begin
                  err_ttl_o <= 1'b1;
                  state     <= IDLE;
                end
              end else begin
                dfx[base +: FLIT_PAYLOAD] <= f_pay;
                exp_seq <= exp_seq + 5'd1;
              end
            end else begin
              err_seq_o <= 1'b1;
              // A stray seq 0 is treated as the start of a fresh packet.
              if (f_seq == 5'd0) begin
                dfx[0 +: FLIT_PAYLOAD] <= f_pay;
                src_q   <= f_src;
                ttl_q   <= f_ttl;
                exp_seq <= 5'd1;
              end else begin
                exp_seq <= 5'd0;
                state   <= IDLE;
              end
            end
          end
        end
        OUTPUT: begin
          if (decode_ready_i) begin
            decode_valid_o <= 1'b0;
            pkt_count_o    <= pkt_count_o + 16'd1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_packet.sv
// Directed and randomized checks of decode_packet against a
// packet-level model built from the DFX word.
module tb_decode_packet;

  logic          clk;
  logic          rst_n;
  logic          flit_valid;
  logic          flit_ready_o;
  logic [63:0]   flit_data;
  logic          decode_valid_o;
  logic          decode_ready;
  logic [1023:0] decode_data_o;
  logic [9:0]    decode_dst_addr_o;
  logic [1:0]    decode_src_o;
  logic [1:0]    decode_ttl_o;
  logic          err_seq_o;
  logic          err_ttl_o;
  logic [15:0]   pkt_count_o;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  int max_gap = 0;

  logic [1033:0] cur_dfx;
  logic [1:0]    cur_src;
  logic [1:0]    cur_ttl;

  decode_packet dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flit_valid_i      (flit_valid),
    .flit_ready_o      (flit_ready_o),
    .flit_data_i       (flit_data),
    .decode_valid_o    (decode_valid_o),
    .decode_ready_i    (decode_ready),
    .decode_data_o     (decode_data_o),
    .decode_dst_addr_o (decode_dst_addr_o),
    .decode_src_o      (decode_src_o),
    .decode_ttl_o      (decode_ttl_o),
    .err_seq_o         (err_seq_o),
    .err_ttl_o         (err_ttl_o),
    .pkt_count_o       (pkt_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [1033:0] obs,
                     input logic [1033:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs[199:0], exp_v[199:0]);
    end
  endtask

  // Flit k carries DFX bits [k*55 +: 55]; the last one carries the
  // top 44 bits with random filler above them.
  function automatic logic [63:0] build_flit(input int k);
    logic [63:0] f;
    f[1:0] = cur_src;
    f[6:2] = 5'(k);
    f[8:7] = cur_ttl;
    if (k < 18) f[63:9] = cur_dfx[k*55 +: 55];
    else        f[63:9] = {11'($urandom), cur_dfx[1033:990]};
    return f;
  endfunction

  task automatic new_pkt();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[32*i +: 32] = $urandom;
    cur_dfx = t[1033:0];
    cur_src = 2'($urandom);
    cur_ttl = 2'($urandom_range(1, 3));
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_flit(input logic [63:0] f);
    int n;
    n = 0;
    flit_valid = 1'b1;
    flit_data  = f;
    while (!flit_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL flit_timeout observed=stalled expected=accepted");
    end
    @(negedge clk);
    flit_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_flit(build_flit(k));
    end
  endtask

  // Checks the packet right after its last flit, with ready high.
  task automatic deliver(input string tag);
    chk({tag, "_valid"}, decode_valid_o, 1'b1);
    chk({tag, "_data"}, decode_data_o, cur_dfx[1033:10]);
    chk({tag, "_addr"}, decode_dst_addr_o, cur_dfx[9:0]);
    chk({tag, "_src"}, decode_src_o, cur_src);
    chk({tag, "_ttl"}, decode_ttl_o, cur_ttl);
    chk({tag, "_errs"}, {err_seq_o, err_ttl_o}, 2'b00);
    @(negedge clk);
    exp_count++;
    chk({tag, "_drop"}, decode_valid_o, 1'b0);
    chk({tag, "_count"}, pkt_count_o, 16'(exp_count));
    chk({tag, "_fready"}, flit_ready_o, 1'b1);
  endtask

  initial begin
    logic [1023:0] d;
    logic [1023:0] held;

    rst_n        = 1'b0;
    flit_valid   = 1'b0;
    flit_data    = '0;
    decode_ready = 1'b0;
    cur_dfx      = '0;
    cur_src      = '0;
    cur_ttl      = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", decode_valid_o, 1'b0);
    chk("rst_data", decode_data_o, '0);
    chk("rst_count", pkt_count_o, '0);
    chk("rst_errs", {err_seq_o, err_ttl_o}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // Single packet with incrementing bytes
    decode_ready = 1'b1;
    for (int i = 0; i < 128; i++) d[8*i +: 8] = 8'(i);
    cur_dfx = {d, 10'h2A5};
    cur_src = 2'b01;
    cur_ttl = 2'b11;
    send_range(0, 17);
    chk("t1_early_valid", decode_valid_o, 1'b0);
    send_range(18, 18);
    deliver("t1");

    // Backpressure
    decode_ready = 1'b0;
    new_pkt();
    send_range(0, 18);
    chk("t2_valid", decode_valid_o, 1'b1);
    held = decode_data_o;
    chk("t2_data", held, cur_dfx[1033:10]);
    for (int i = 0; i < 10; i++) begin
      flit_valid = 1'b1;
      flit_data  = 64'($urandom) & ~64'h7C;
      @(negedge clk);
      chk("t2_hold_valid", decode_valid_o, 1'b1);
      chk("t2_hold_data", decode_data_o, held);
      chk("t2_hold_addr", decode_dst_addr_o, cur_dfx[9:0]);
      chk("t2_fready", flit_ready_o, 1'b0);
    end
    flit_valid   = 1'b0;
    decode_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    chk("t2_drop", decode_valid_o, 1'b0);
    chk("t2_count", pkt_count_o, 16'(exp_count));
    chk("t2_fready_back", flit_ready_o, 1'b1);

    // Sequence gap 0..6 then 8
    new_pkt();
    send_range(0, 6);
    send_flit(build_flit(8));
    chk("t3_err_seq", err_seq_o, 1'b1);
    chk("t3_err_ttl", err_ttl_o, 1'b0);
    chk("t3_valid", decode_valid_o, 1'b0);
    @(negedge clk);
    chk("t3_err_seq_end", err_seq_o, 1'b0);
    new_pkt();
    send_range(0, 18);
    deliver("t3");

    // Resync on a fresh seq 0
    new_pkt();
    send_range(0, 4);
    new_pkt();
    send_range(0, 0);
    chk("t4_err_seq", err_seq_o, 1'b1);
    send_range(1, 1);
    chk("t4_err_seq_end", err_seq_o, 1'b0);
    send_range(2, 18);
    deliver("t4");

    // TTL 0 is dropped
    new_pkt();
    cur_ttl = 2'b00;
    send_range(0, 18);
    chk("t5_err_ttl", err_ttl_o, 1'b1);
    chk("t5_err_seq", err_seq_o, 1'b0);
    chk("t5_valid", decode_valid_o, 1'b0);
    @(negedge clk);
    chk("t5_err_ttl_end", err_ttl_o, 1'b0);
    chk("t5_valid_end", decode_valid_o, 1'b0);
    chk("t5_count", pkt_count_o, 16'(exp_count));

    // Reset after flit 9
    new_pkt();
    send_range(0, 9);
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    chk("t6_valid", decode_valid_o, 1'b0);
    chk("t6_data", decode_data_o, '0);
    chk("t6_addr", decode_dst_addr_o, '0);
    chk("t6_srcttl", {decode_src_o, decode_ttl_o}, 4'b0);
    chk("t6_errs", {err_seq_o, err_ttl_o}, 2'b00);
    chk("t6_count", pkt_count_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    new_pkt();
    send_range(0, 18);
    deliver("t6");

    // Random packets with idle gaps between flits
    max_gap = 3;
    for (int p = 0; p < 6; p++) begin
      new_pkt();
      send_range(0, 18);
      deliver("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
